// File: rtl/ysyx_22040000_axil_pkg.sv
// Shared definitions for the AXI4-Lite SRAM responder: response codes,
// channel state encodings and bus widths.
package ysyx_22040000_axil_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int CNT_W  = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

endpackage

// File: rtl/ysyx_22040000_axil_lat_cnt.sv
// 8-bit loadable down-counter that paces one channel's response latency.
// The zero flag is decoded straight from the count register.
module ysyx_22040000_axil_lat_cnt
    import ysyx_22040000_axil_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ysyx_22040000_axil_sram.sv
// AXI4-Lite word-addressed SRAM responder with independent read and write
// channels, each holding one transaction and answering after LATENCY+1 cycles.
module ysyx_22040000_axil_sram
    import ysyx_22040000_axil_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAT_VAL = CNT_W'(LATENCY);

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return 64'(idx) < 64'(DEPTH);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{araddr[1:0], awaddr[1:0]};

    // ---------------- read channel ----------------
    r_state_e          r_state, r_next;
    logic [MEM_AW-1:0] r_idx;
    logic              r_ok;
    logic              r_load, r_dec, r_capture, r_zero, ar_hs;

    assign arready = (r_state == R_IDLE);
    assign rvalid  = (r_state == R_RESP);
    assign ar_hs   = arvalid & arready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next    = r_state;
        r_load    = 1'b0;
        r_dec     = 1'b0;
        r_capture = 1'b0;
        case (r_state)
            R_IDLE: if (arvalid) begin
                r_next = R_WAIT;
                r_load = 1'b1;
            end
            R_WAIT: if (r_zero) begin
                r_next    = R_RESP;
                r_capture = 1'b1;
            end else begin
                r_dec = 1'b1;
            end
            R_RESP: if (rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_ok  <= 1'b0;
            rdata <= '0;
            rresp <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                r_idx <= araddr[MEM_AW+1:2];
                r_ok  <= in_range(araddr[ADDR_W-1:2]);
            end
            // Sampled on the same edge as any write commit, so a colliding read sees old data.
            if (r_capture) begin
                rdata <= r_ok ? mem[r_idx] : '0;
                rresp <= r_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    ysyx_22040000_axil_lat_cnt u_r_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (r_load),
        .load_val (LAT_VAL),
        .dec      (r_dec),
        .zero     (r_zero)
    );

    // ---------------- write channel ----------------
    w_state_e          w_state, w_next;
    logic              aw_held, w_held;
    logic [MEM_AW-1:0] w_idx;
    logic              w_ok;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              w_load, w_dec, w_commit, w_zero, aw_hs, w_hs;

    assign awready = (w_state == W_IDLE) && !aw_held;
    assign wready  = (w_state == W_IDLE) && !w_held;
    assign bvalid  = (w_state == W_RESP);
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        w_next   = w_state;
        w_load   = 1'b0;
        w_dec    = 1'b0;
        w_commit = 1'b0;
        case (w_state)
            W_IDLE: if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                w_next = W_WAIT;
                w_load = 1'b1;
            end
            W_WAIT: if (w_zero) begin
                w_next   = W_RESP;
                w_commit = 1'b1;
            end else begin
                w_dec = 1'b1;
            end
            W_RESP: if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            w_idx   <= '0;
            w_ok    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bresp   <= RESP_OKAY;
        end else begin
            // Held flags only matter in W_IDLE; readies are state-gated afterwards.
            if (w_load) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs)  w_held  <= 1'b1;
            end
            if (aw_hs) begin
                w_idx <= awaddr[MEM_AW+1:2];
                w_ok  <= in_range(awaddr[ADDR_W-1:2]);
            end
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (w_commit) bresp <= w_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit && w_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_q[b]) mem[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    ysyx_22040000_axil_lat_cnt u_w_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (LAT_VAL),
        .dec      (w_dec),
        .zero     (w_zero)
    );

endmodule

// File: tb/tb_ysyx_22040000_axil_sram.sv
// Bench for the AXI4-Lite SRAM responder: three instances (latency 0, 3, 5)
// driven by handshake tasks, with a scoreboard monitor checking every response.
module tb_ysyx_22040000_axil_sram;

    localparam int NI    = 3;
    localparam int DEPTH = 1024;
    localparam int TMO   = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] araddr  [NI];
    logic        arvalid [NI];
    logic        arready [NI];
    logic [31:0] rdata   [NI];
    logic [1:0]  rresp   [NI];
    logic        rvalid  [NI];
    logic        rready  [NI];
    logic [31:0] awaddr  [NI];
    logic        awvalid [NI];
    logic        awready [NI];
    logic [31:0] wdata   [NI];
    logic [3:0]  wstrb   [NI];
    logic        wvalid  [NI];
    logic        wready  [NI];
    logic [1:0]  bresp   [NI];
    logic        bvalid  [NI];
    logic        bready  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ysyx_22040000_axil_sram #(
            .ADDR_W  (32),
            .DEPTH   (DEPTH),
            .LATENCY ((g == 0) ? 0 : ((g == 1) ? 3 : 5))
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .araddr  (araddr[g]),
            .arvalid (arvalid[g]),
            .arready (arready[g]),
            .rdata   (rdata[g]),
            .rresp   (rresp[g]),
            .rvalid  (rvalid[g]),
            .rready  (rready[g]),
            .awaddr  (awaddr[g]),
            .awvalid (awvalid[g]),
            .awready (awready[g]),
            .wdata   (wdata[g]),
            .wstrb   (wstrb[g]),
            .wvalid  (wvalid[g]),
            .wready  (wready[g]),
            .bresp   (bresp[g]),
            .bvalid  (bvalid[g]),
            .bready  (bready[g])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 3 : 5);
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        int          inst;
        logic [31:0] data;
        logic [1:0]  resp;
        int          due;
    } exp_t;

    exp_t rq[$];
    exp_t wq[$];
    exp_t r_cur [NI];
    exp_t w_cur [NI];
    logic r_prev [NI] = '{default: 1'b0};
    logic w_prev [NI] = '{default: 1'b0};

    logic [31:0] model [NI][DEPTH];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=no_event t=%0t", name, $time);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rvalid[i] && !r_prev[i]) begin
                if (rq.size() == 0) begin
                    fail_evt("r_unexpected");
                end else begin
                    r_cur[i] = rq.pop_front();
                    check("r_inst", i, r_cur[i].inst);
                    check("r_latency", cyc, r_cur[i].due);
                    check("rdata", rdata[i], r_cur[i].data);
                    check("rresp", 32'(rresp[i]), 32'(r_cur[i].resp));
                end
            end else if (rvalid[i]) begin
                check("rdata_hold", rdata[i], r_cur[i].data);
                check("rresp_hold", 32'(rresp[i]), 32'(r_cur[i].resp));
            end
            r_prev[i] = rvalid[i];

            if (bvalid[i] && !w_prev[i]) begin
                if (wq.size() == 0) begin
                    fail_evt("b_unexpected");
                end else begin
                    w_cur[i] = wq.pop_front();
                    check("b_inst", i, w_cur[i].inst);
                    check("b_latency", cyc, w_cur[i].due);
                    check("bresp", 32'(bresp[i]), 32'(w_cur[i].resp));
                end
            end else if (bvalid[i]) begin
                check("bresp_hold", 32'(bresp[i]), 32'(w_cur[i].resp));
            end
            w_prev[i] = bvalid[i];
        end
    end

    // ---------------- drivers ----------------
    // Tasks start and end at posedge+1; readies/valids are sampled on negedge.
    task automatic wait_accept(input int i, input int ch, input string name, output int hs);
        logic ok;
        int   n;
        n  = 0;
        hs = -1;
        while (n < TMO) begin
            @(negedge clk);
            ok = (ch == 0) ? arready[i] : ((ch == 1) ? awready[i] : wready[i]);
            @(posedge clk);
            #1;
            n++;
            if (ok) begin
                hs = cyc;
                break;
            end
        end
        if (hs < 0) fail_evt({name, "_accept_timeout"});
    endtask

    task automatic wait_resp(input int i, input int ch, input int dly);
        logic v;
        logic seen;
        int   n;
        n    = 0;
        seen = 1'b0;
        while (n < TMO) begin
            @(negedge clk);
            v = (ch == 0) ? rvalid[i] : bvalid[i];
            if (v) begin
                seen = 1'b1;
                break;
            end
            n++;
        end
        if (!seen) begin
            fail_evt((ch == 0) ? "rvalid_timeout" : "bvalid_timeout");
            @(posedge clk);
            #1;
        end else begin
            for (int k = 0; k < dly; k++) begin
                @(negedge clk);
                if (ch == 0) begin
                    check("arready_busy", 32'(arready[i]), 32'd0);
                end else begin
                    check("awready_busy", 32'(awready[i]), 32'd0);
                    check("wready_busy", 32'(wready[i]), 32'd0);
                end
            end
            if (ch == 0) rready[i] = 1'b1;
            else         bready[i] = 1'b1;
            @(posedge clk);
            #1;
            if (ch == 0) begin
                rready[i] = 1'b0;
                check("arready_after_r", 32'(arready[i]), 32'd1);
                check("rvalid_after_r", 32'(rvalid[i]), 32'd0);
            end else begin
                bready[i] = 1'b0;
                check("awready_after_b", 32'(awready[i]), 32'd1);
                check("wready_after_b", 32'(wready[i]), 32'd1);
                check("bvalid_after_b", 32'(bvalid[i]), 32'd0);
            end
        end
    endtask

    task automatic issue_write(input int i, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input int aw_pre, input int w_pre,
                               output int hs);
        int h_aw;
        int h_w;
        fork
            begin
                repeat (aw_pre) @(posedge clk);
                if (aw_pre > 0) #1;
                awaddr[i]  = a;
                awvalid[i] = 1'b1;
                wait_accept(i, 1, "aw", h_aw);
                awvalid[i] = 1'b0;
                check("awready_low_after_aw", 32'(awready[i]), 32'd0);
            end
            begin
                repeat (w_pre) @(posedge clk);
                if (w_pre > 0) #1;
                wdata[i]  = d;
                wstrb[i]  = s;
                wvalid[i] = 1'b1;
                wait_accept(i, 2, "w", h_w);
                wvalid[i] = 1'b0;
                check("wready_low_after_w", 32'(wready[i]), 32'd0);
            end
        join
        hs = (h_aw > h_w) ? h_aw : h_w;
    endtask

    task automatic do_write(input int i, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int aw_pre, input int w_pre,
                            input int bdly);
        int          hs;
        logic [29:0] idx;
        logic        ok;
        exp_t        e;
        issue_write(i, a, d, s, aw_pre, w_pre, hs);
        idx    = a[31:2];
        ok     = (idx < DEPTH);
        e.inst = i;
        e.data = '0;
        e.resp = ok ? 2'b00 : 2'b10;
        e.due  = hs + lat_of(i) + 1;
        wq.push_back(e);
        wait_resp(i, 1, bdly);
        if (ok) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[i][idx][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic do_read(input int i, input logic [31:0] a, input int pre, input int rdly);
        int          hs;
        logic [29:0] idx;
        logic        ok;
        exp_t        e;
        repeat (pre) @(posedge clk);
        if (pre > 0) #1;
        araddr[i]  = a;
        arvalid[i] = 1'b1;
        wait_accept(i, 0, "ar", hs);
        arvalid[i] = 1'b0;
        check("arready_low_after_ar", 32'(arready[i]), 32'd0);
        idx    = a[31:2];
        ok     = (idx < DEPTH);
        e.inst = i;
        e.data = ok ? model[i][idx] : 32'h0;
        e.resp = ok ? 2'b00 : 2'b10;
        e.due  = hs + lat_of(i) + 1;
        rq.push_back(e);
        wait_resp(i, 0, rdly);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int hs;
        for (int i = 0; i < NI; i++) begin
            araddr[i] = '0; arvalid[i] = 1'b0; rready[i] = 1'b0;
            awaddr[i] = '0; awvalid[i] = 1'b0; wdata[i] = '0;
            wstrb[i] = '0;  wvalid[i] = 1'b0;  bready[i] = 1'b0;
            for (int w = 0; w < DEPTH; w++) model[i][w] = '0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst_arready", 32'(arready[i]), 32'd1);
            check("rst_awready", 32'(awready[i]), 32'd1);
            check("rst_wready", 32'(wready[i]), 32'd1);
            check("rst_rvalid", 32'(rvalid[i]), 32'd0);
            check("rst_bvalid", 32'(bvalid[i]), 32'd0);
            check("rst_rdata", rdata[i], 32'd0);
            check("rst_rresp", 32'(rresp[i]), 32'd0);
            check("rst_bresp", 32'(bresp[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NI; i++) begin
            for (int w = 0; w < 17; w++) do_write(i, 32'(w * 4), $urandom, 4'hF, 0, 0, 0);
        end

        // Full and partial strobe writes, sub-word address bits ignored
        do_write(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_read(0, 32'h10, 0, 0);
        do_write(0, 32'h10, 32'h11223344, 4'b0101, 0, 0, 0);
        do_read(0, 32'h12, 0, 0);
        // W one cycle ahead of AW, bready held off five cycles
        do_write(0, 32'h20, 32'h55AA0FF0, 4'hF, 1, 0, 5);
        do_read(0, 32'h20, 0, 2);
        do_write(0, 32'h24, 32'hFFFFFFFF, 4'h0, 0, 1, 0);
        do_read(0, 32'h24, 0, 0);

        // Out of range on the latency-3 instance; index 0 must stay intact
        do_read(1, 32'h1000, 0, 0);
        do_write(1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, 0, 1);
        do_read(1, 32'h0, 0, 0);
        do_read(1, 32'h0, 0, 0);

        // Same-edge collision: read captures while the write commits
        do_write(0, 32'h40, 32'h0, 4'hF, 0, 0, 0);
        fork
            do_write(0, 32'h40, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
            do_read(0, 32'h40, 0, 0);
        join
        do_read(0, 32'h40, 0, 0);

        // Reset while a write waits out its latency on the latency-5 instance
        do_write(2, 32'h14, 32'hCAFEF00D, 4'hF, 0, 0, 0);
        issue_write(2, 32'h14, 32'h12345678, 4'hF, 0, 0, hs);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NI; i++) begin
            check("rstmid_arready", 32'(arready[i]), 32'd1);
            check("rstmid_awready", 32'(awready[i]), 32'd1);
            check("rstmid_wready", 32'(wready[i]), 32'd1);
            check("rstmid_bvalid", 32'(bvalid[i]), 32'd0);
        end
        repeat (12) @(posedge clk);
        #1;
        do_read(2, 32'h14, 0, 0);

        // Randomized traffic per instance
        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < 40; n++) begin
                int          w;
                logic [31:0] a;
                if ($urandom_range(0, 7) == 0) w = DEPTH + int'($urandom_range(0, 15));
                else                           w = int'($urandom_range(0, 15));
                a = 32'(w * 4) | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 0) begin
                    do_write(i, a, $urandom, 4'($urandom_range(0, 15)),
                             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                             int'($urandom_range(0, 3)));
                end else begin
                    do_read(i, a, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
                end
            end
        end

        repeat (10) @(posedge clk);
        #1;
        check("rq_drained", rq.size(), 32'd0);
        check("wq_drained", wq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
